// File: rtl/fifo_drain_reader.sv
// Consumer-side reader for the slow-clock FIFO: pops one word at a time, holds it on a
// display register with 7-segment decode, and keeps a running word count and XOR checksum.
module fifo_drain_reader #(
   parameter int unsigned DATA_WIDTH  = 4,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned COUNT_WIDTH = 8
) (
   input  logic                   reset,
   input  logic                   slow_clk,
   input  logic                   enable,
   input  logic                   fifo_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_dout,
   output logic                   fifo_rd_en,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   data_valid,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] word_count,
   output logic [DATA_WIDTH-1:0]  checksum,
   output logic [6:0]             seg
);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StHold
   } state_e;

   localparam logic [7:0] HoldInit = 8'(HOLD_CYCLES - 1);

   state_e                 state_q, state_d;
   logic                   rd_en_q, rd_en_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   valid_q, valid_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0]  sum_q, sum_d;
   logic [7:0]             hold_q, hold_d;

   always_ff @(posedge slow_clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         rd_en_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         sum_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         rd_en_q <= rd_en_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
         sum_q   <= sum_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rd_en_d = 1'b0;
      data_d  = data_q;
      valid_d = 1'b0;
      count_d = count_q;
      sum_d   = sum_q;
      hold_d  = hold_q;
      case (state_q)
         StIdle: begin
            if (enable && !fifo_empty) begin
               state_d = StReq;
               rd_en_d = 1'b1;
            end
         end
         StReq: begin
            state_d = StWait;
         end
         // FIFO output is registered, so the popped word is visible one cycle after REQ
         StWait: begin
            data_d  = fifo_dout;
            valid_d = 1'b1;
            count_d = count_q + COUNT_WIDTH'(1);
            sum_d   = sum_q ^ fifo_dout;
            hold_d  = HoldInit;
            state_d = StHold;
         end
         StHold: begin
            if (hold_q == 8'd0) begin
               state_d = StIdle;
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      seg = 7'b1000000;
      case (data_q[3:0])
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1000000;
      endcase
   end

   assign fifo_rd_en = rd_en_q;
   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign busy       = (state_q != StIdle);
   assign word_count = count_q;
   assign checksum   = sum_q;

endmodule
